// File: rtl/pulse_acq_ctrl.sv
// pulse_acq_ctrl: lidar acquisition sequencer. It synchronises the laser
// trigger, waits a programmed delay, and fires a one-cycle start to the
// range-bin FIFO stage. It then waits for the read-out and repeats for the
// programmed pulse count. It also tracks missed triggers and read-out timeouts.
module pulse_acq_ctrl #(
    parameter int unsigned DLY_W       = 16,
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned TIMEOUT_CYC = 65536
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             trig_in,
    input  logic             arm,
    input  logic             abort,
    input  logic [DLY_W-1:0] cfg_delay,
    input  logic [CNT_W-1:0] cfg_pulses,
    input  logic             fifo_data_valid,
    output logic             start_out,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] pulse_idx,
    output logic [CNT_W-1:0] missed_cnt,
    output logic             err_timeout
);

    localparam int unsigned TW = $clog2(TIMEOUT_CYC) + 1;
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC - 1);

    typedef enum logic [5:0] {
        IDLE      = 6'b000001,
        WAIT_TRIG = 6'b000010,
        DELAY     = 6'b000100,
        FIRE      = 6'b001000,
        WAIT_READ = 6'b010000,
        DONE      = 6'b100000
    } state_t;

    state_t           state_q, state_d;
    logic             trig_s1_q, trig_s1_d;
    logic             trig_s2_q, trig_s2_d;
    logic             trig_s3_q, trig_s3_d;
    logic [DLY_W-1:0] dly_l_q, dly_l_d;
    logic [CNT_W-1:0] npul_l_q, npul_l_d;
    logic [DLY_W-1:0] dcnt_q, dcnt_d;
    logic [TW-1:0]    tcnt_q, tcnt_d;
    logic             seen_valid_q, seen_valid_d;
    logic [CNT_W-1:0] pulse_idx_q, pulse_idx_d;
    logic [CNT_W-1:0] missed_cnt_q, missed_cnt_d;
    logic             err_timeout_q, err_timeout_d;
    logic             start_out_q, start_out_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;

    logic             trig_rise;
    logic [CNT_W-1:0] pulse_inc;
    logic [TW-1:0]    tcnt_inc;

    assign trig_rise = trig_s2_q & ~trig_s3_q;
    assign pulse_inc = pulse_idx_q + 1'b1;
    assign tcnt_inc  = tcnt_q + 1'b1;

    // Register every piece of state; asynchronous reset returns all to idle values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            trig_s1_q     <= 1'b0;
            trig_s2_q     <= 1'b0;
            trig_s3_q     <= 1'b0;
            dly_l_q       <= '0;
            npul_l_q      <= '0;
            dcnt_q        <= '0;
            tcnt_q        <= '0;
            seen_valid_q  <= 1'b0;
            pulse_idx_q   <= '0;
            missed_cnt_q  <= '0;
            err_timeout_q <= 1'b0;
            start_out_q   <= 1'b0;
            done_q        <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            trig_s1_q     <= trig_s1_d;
            trig_s2_q     <= trig_s2_d;
            trig_s3_q     <= trig_s3_d;
            dly_l_q       <= dly_l_d;
            npul_l_q      <= npul_l_d;
            dcnt_q        <= dcnt_d;
            tcnt_q        <= tcnt_d;
            seen_valid_q  <= seen_valid_d;
            pulse_idx_q   <= pulse_idx_d;
            missed_cnt_q  <= missed_cnt_d;
            err_timeout_q <= err_timeout_d;
            start_out_q   <= start_out_d;
            done_q        <= done_d;
            busy_q        <= busy_d;
        end
    end

    // Next-state, counters and registered outputs; abort overrides all transitions.
    always_comb begin
        state_d       = state_q;
        trig_s1_d     = trig_in;
        trig_s2_d     = trig_s1_q;
        trig_s3_d     = trig_s2_q;
        dly_l_d       = dly_l_q;
        npul_l_d      = npul_l_q;
        dcnt_d        = dcnt_q;
        tcnt_d        = tcnt_q;
        seen_valid_d  = seen_valid_q;
        pulse_idx_d   = pulse_idx_q;
        missed_cnt_d  = missed_cnt_q;
        err_timeout_d = err_timeout_q;

        if (trig_rise && (state_q inside {DELAY, FIRE, WAIT_READ, DONE}) &&
            (missed_cnt_q != '1)) begin
            missed_cnt_d = missed_cnt_q + 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (arm) begin
                    dly_l_d       = cfg_delay;
                    npul_l_d      = (cfg_pulses == '0) ? CNT_W'(1) : cfg_pulses;
                    pulse_idx_d   = '0;
                    missed_cnt_d  = '0;
                    err_timeout_d = 1'b0;
                    state_d       = WAIT_TRIG;
                end
            end
            WAIT_TRIG: begin
                if (trig_rise) begin
                    dcnt_d  = '0;
                    state_d = DELAY;
                end
            end
            DELAY: begin
                if (dcnt_q == dly_l_q) begin
                    state_d = FIRE;
                end else begin
                    dcnt_d = dcnt_q + 1'b1;
                end
            end
            FIRE: begin
                seen_valid_d = 1'b0;
                tcnt_d       = '0;
                state_d      = WAIT_READ;
            end
            WAIT_READ: begin
                if (fifo_data_valid) begin
                    seen_valid_d = 1'b1;
                end
                if (seen_valid_q && !fifo_data_valid) begin
                    pulse_idx_d = pulse_inc;
                    state_d     = (pulse_inc == npul_l_q) ? DONE : WAIT_TRIG;
                end else begin
                    tcnt_d = tcnt_inc;
                    if (tcnt_inc >= TO_LAST) begin
                        err_timeout_d = 1'b1;
                        state_d       = IDLE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (abort && (state_q != IDLE)) begin
            state_d       = IDLE;
            pulse_idx_d   = pulse_idx_q;
            err_timeout_d = err_timeout_q;
        end

        start_out_d = (state_d == FIRE);
        done_d      = (state_d == DONE);
        busy_d      = (state_d != IDLE);
    end

    assign start_out   = start_out_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign pulse_idx   = pulse_idx_q;
    assign missed_cnt  = missed_cnt_q;
    assign err_timeout = err_timeout_q;

endmodule

// File: doc/pulse_acq_ctrl.md
# pulse_acq_ctrl

Acquisition sequencer for the lidar receive chain. It synchronises the external laser trigger, waits a programmable delay, then issues a one-cycle `start` to the range-bin FIFO stage. It waits for that stage to finish streaming the pulse before re-arming, repeats for a programmed number of pulses, and reports missed triggers and read-out timeouts.

## Interface
- `DLY_W`, 16: width of the trigger-to-start delay configuration.
- `CNT_W`, 16: width of the pulse counter and the missed-trigger counter.
- `TIMEOUT_CYC`, 65536: maximum clocks allowed in WAIT_READ per pulse.

- `clk`  in  1: system clock; all logic on the rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `trig_in`  in  1: raw laser trigger, asynchronous to `clk`, level.
- `arm`  in  1: one-cycle pulse; begins an acquisition.
- `abort`  in  1: one-cycle pulse; cancels the acquisition.
- `cfg_delay`  in  DLY_W: clocks from the synchronised trigger edge to `start_out`.
- `cfg_pulses`  in  CNT_W: pulses per acquisition; 0 is treated as 1.
- `fifo_data_valid`  in  1: `data_valid` from the range-bin FIFO stage; high while it is streaming.
- `start_out`  out  1: one-cycle start pulse to the FIFO stage.
- `busy`  out  1: high in every state except IDLE.
- `done`  out  1: one-cycle pulse when all pulses have completed.
- `pulse_idx`  out  CNT_W: number of pulses completed in the current acquisition.
- `missed_cnt`  out  CNT_W: triggers ignored because the block was not in WAIT_TRIG; saturates at all-ones.
- `err_timeout`  out  1: sticky; set when a read-out times out.

## Operation
- **Trigger path:** `trig_in` passes through a 2-FF synchroniser (s1, s2) plus a history register s3. `trig_rise = s2 & ~s3`. Reset clears all three.
- **States** (one-hot): IDLE, WAIT_TRIG, DELAY, FIRE, WAIT_READ, DONE.
- **IDLE:**
  - On `arm`: latch `cfg_delay` into `dly_l`.
  - Latch `cfg_pulses` into `npul_l`, with 0 replaced by 1.
  - Clear `pulse_idx`, `missed_cnt` and `err_timeout`.
  - Go to WAIT_TRIG.
  - `arm` in any other state is ignored.
- **WAIT_TRIG:** on `trig_rise`, clear the delay counter and go to DELAY.
- **DELAY:**
  - If the counter equals `dly_l`, go to FIRE.
  - Otherwise increment the counter.
  - DELAY therefore lasts `dly_l` + 1 cycles.
- **FIRE:** lasts exactly one cycle. Clear `seen_valid` and the timeout counter, then go to WAIT_READ.
- **WAIT_READ:**
  - `fifo_data_valid` = 1 sets `seen_valid`.
  - When `seen_valid` = 1 and `fifo_data_valid` = 0:
    - increment `pulse_idx`;
    - if the new value equals `npul_l`, go to DONE;
    - otherwise go to WAIT_TRIG.
  - The timeout counter increments every cycle spent in WAIT_READ. When it reaches `TIMEOUT_CYC` - 1 without a completion, set `err_timeout` and go to IDLE; `done` is not pulsed.
- **DONE:** one cycle, then go to IDLE.
- **abort:**
  - Highest priority. From any non-IDLE state, go to IDLE on the next edge; `done` is not pulsed.
  - `pulse_idx` and `missed_cnt` hold their values until the next `arm`.
- **Missed triggers:** `trig_rise` in DELAY, FIRE, WAIT_READ or DONE increments `missed_cnt`, saturating. `trig_rise` in IDLE is not counted.
- **Simultaneous events:**
  - `trig_rise` together with the WAIT_READ completion counts as missed; the next trigger is used.
  - `abort` together with completion: abort wins, `pulse_idx` is not incremented.

## Timing
- **Reset values:** state IDLE; `start_out`, `busy`, `done` and `err_timeout` = 0; `pulse_idx` and `missed_cnt` = 0.
- **Output registers:**
  - `start_out` is registered and high exactly for the cycle in which state = FIRE.
  - `done` is registered and high exactly for the cycle in which state = DONE.
  - `busy` = (state != IDLE), registered.
- **Trigger latency:** if `trig_in` rises before edge E0 while in WAIT_TRIG, `trig_rise` is high after edge E1, state = DELAY after E2, and `start_out` is high in the cycle after edge E(`dly_l` + 3).
- **Arm latency:** `arm` sampled at edge E0 gives state WAIT_TRIG and `busy` = 1 after E0.
- **Completion latency:** the `fifo_data_valid` falling edge is sampled at edge F. `pulse_idx` updates at F. Then either state = WAIT_TRIG after F, or `done` is high for the cycle after F.
- **Mid-operation reset:** reset asynchronously returns every register to its reset value; `start_out` drops immediately.

## Test plan
- **Single pulse, zero delay:** `arm`, `cfg_delay`=0, `cfg_pulses`=1, `trig_in` high before E0 → `start_out` high in the cycle after E3. Then drive `fifo_data_valid` high for 1024 cycles and low → `pulse_idx`=1, one `done` pulse, `busy`=0 one cycle after `done`.
- **Multi-pulse:** `cfg_pulses`=3, `cfg_delay`=10 → three `start_out` pulses, each 13 edges after its trigger edge; `done` follows the third read-out only; `pulse_idx`=3.
- **Missed triggers:** during WAIT_READ, toggle `trig_in` twice (each level held ≥ 3 cycles) → `missed_cnt`=2, no extra `start_out`. A trigger during IDLE → `missed_cnt` unchanged.
- **Timeout:** `TIMEOUT_CYC`=16 and `fifo_data_valid` held 0 after FIRE → `err_timeout`=1 after 15 WAIT_READ cycles, state IDLE, no `done`.
- **Abort:** abort in DELAY → no `start_out`, `busy`=0 after the next edge. Abort in the same cycle as read-out completion → `pulse_idx` unchanged, no `done`.
- **Config edge cases:**
  - `cfg_pulses`=0 behaves as 1.
  - `arm` while busy is ignored.
  - `rst` asserted in WAIT_READ clears all outputs asynchronously.
